// File: rtl/isa_defs.sv
// Shared ISA definitions for the instruction encoder and decoder.
// Holds ALU op codes, instruction opcodes, the instruction word layout
// and the encode() helper mapping an ALU request to an opcode.
package isa_defs;

  localparam int unsigned FIELD_W = 4;
  localparam int unsigned INSTR_W = 16;

  // ALU operation codes as presented on the request side
  localparam logic [FIELD_W-1:0] ALUADD = 4'h0;
  localparam logic [FIELD_W-1:0] ALUSUB = 4'h1;
  localparam logic [FIELD_W-1:0] ALUSLT = 4'h2;
  localparam logic [FIELD_W-1:0] ALUAND = 4'h3;
  localparam logic [FIELD_W-1:0] ALUOR  = 4'h4;
  localparam logic [FIELD_W-1:0] ALUXOR = 4'h5;

  // Instruction opcodes in bits [15:12] of the encoded word
  localparam logic [FIELD_W-1:0] InsADD  = 4'h0;
  localparam logic [FIELD_W-1:0] InsSUB  = 4'h1;
  localparam logic [FIELD_W-1:0] InsSLT  = 4'h2;
  localparam logic [FIELD_W-1:0] InsAND  = 4'h3;
  localparam logic [FIELD_W-1:0] InsOR   = 4'h4;
  localparam logic [FIELD_W-1:0] InsXOR  = 4'h5;
  localparam logic [FIELD_W-1:0] InsANDI = 4'h6;
  localparam logic [FIELD_W-1:0] InsORI  = 4'h7;
  localparam logic [FIELD_W-1:0] InsXORI = 4'h8;
  localparam logic [FIELD_W-1:0] InsADDI = 4'h9;
  localparam logic [FIELD_W-1:0] InsSUBI = 4'hA;

  // Encoded instruction word layout
  typedef struct packed {
    logic [FIELD_W-1:0] opcode;
    logic [FIELD_W-1:0] dst;
    logic [FIELD_W-1:0] srcb;
    logic [FIELD_W-1:0] srca;
  } instr_t;

  // Result of encode(): legal flag plus opcode
  typedef struct packed {
    logic               legal;
    logic [FIELD_W-1:0] opcode;
  } enc_t;

  // Map {ALU op, immediate form} to an opcode; SLT has only an immediate form
  function automatic enc_t encode(input logic [FIELD_W-1:0] op, input logic is_imm);
    enc_t res;
    res = '{legal: 1'b0, opcode: InsADD};
    if (is_imm) begin
      case (op)
        ALUADD:  res = '{legal: 1'b1, opcode: InsADDI};
        ALUSUB:  res = '{legal: 1'b1, opcode: InsSUBI};
        ALUSLT:  res = '{legal: 1'b1, opcode: InsSLT};
        ALUAND:  res = '{legal: 1'b1, opcode: InsANDI};
        ALUOR:   res = '{legal: 1'b1, opcode: InsORI};
        ALUXOR:  res = '{legal: 1'b1, opcode: InsXORI};
        default: res = '{legal: 1'b0, opcode: InsADD};
      endcase
    end else begin
      case (op)
        ALUADD:  res = '{legal: 1'b1, opcode: InsADD};
        ALUSUB:  res = '{legal: 1'b1, opcode: InsSUB};
        ALUAND:  res = '{legal: 1'b1, opcode: InsAND};
        ALUOR:   res = '{legal: 1'b1, opcode: InsOR};
        ALUXOR:  res = '{legal: 1'b1, opcode: InsXOR};
        default: res = '{legal: 1'b0, opcode: InsADD};
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered ready/valid and a registered head word.
// Ports:
//   CLK, RST_N       clock, synchronous active-low reset
//   push, wdata      write request (taken only when in_ready)
//   pop              read request (taken only when out_valid)
//   in_ready         not full
//   out_valid, rdata head word valid / head word (zero when empty)
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [OCC_W-1:0] count;
  logic [OCC_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & in_ready;
  assign do_pop  = pop & out_valid;

  // Next read pointer and occupancy
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (do_pop) begin
      rd_ptr_nxt = PTR_W'(rd_ptr + PTR_W'(1));
    end
    case ({do_push, do_pop})
      2'b10:   count_nxt = OCC_W'(count + OCC_W'(1));
      2'b01:   count_nxt = OCC_W'(count - OCC_W'(1));
      default: count_nxt = count;
    endcase
  end

  // Pointers, flags and head register; head takes wdata when the new
  // word lands directly in the slot that becomes the head
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      rdata     <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
      end
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      in_ready  <= (count_nxt != OCC_W'(DEPTH));
      out_valid <= (count_nxt != '0);
      if (count_nxt == '0) begin
        rdata <= '0;
      end else if (do_push && (wr_ptr == rd_ptr_nxt)) begin
        rdata <= wdata;
      end else begin
        rdata <= mem[rd_ptr_nxt];
      end
    end
  end

  // Storage array
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs ALU requests into 16-bit instruction words, buffers them and issues
// them over a valid/ready link; drops and counts illegal requests.
// Ports:
//   CLK, RST_N                      clock, synchronous active-low reset
//   InValid/InReady                 request handshake
//   OpALU, isImm, Dst, SrcB, SrcA   request fields
//   OutValid/OutReady, Instr        issue handshake and encoded word
//   ErrPulse                        illegal request dropped (one cycle per request)
//   IssueCnt                        words issued, wrapping
//   ErrCnt                          illegal requests, saturating
module instr_encoder
  import isa_defs::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               InValid,
  output logic               InReady,
  input  logic [3:0]         OpALU,
  input  logic               isImm,
  input  logic [3:0]         Dst,
  input  logic [3:0]         SrcB,
  input  logic [3:0]         SrcA,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [15:0]        Instr,
  output logic               ErrPulse,
  output logic [CNT_W-1:0]   IssueCnt,
  output logic [CNT_W-1:0]   ErrCnt
);

  enc_t   enc;
  instr_t word;
  logic   accept;
  logic   push;
  logic   illegal;
  logic   pop;

  assign enc     = encode(OpALU, isImm);
  assign word    = '{opcode: enc.opcode, dst: Dst, srcb: SrcB, srca: SrcA};
  assign accept  = InValid & InReady;
  assign push    = accept & enc.legal;
  assign illegal = accept & ~enc.legal;
  assign pop     = OutValid & OutReady;

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (push),
    .wdata     (word),
    .pop       (pop),
    .in_ready  (InReady),
    .out_valid (OutValid),
    .rdata     (Instr)
  );

  // Error pulse and counters
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ErrPulse <= 1'b0;
      IssueCnt <= '0;
      ErrCnt   <= '0;
    end else begin
      ErrPulse <= illegal;
      if (pop) begin
        IssueCnt <= CNT_W'(IssueCnt + CNT_W'(1));
      end
      if (illegal && (ErrCnt != '1)) begin
        ErrCnt <= CNT_W'(ErrCnt + CNT_W'(1));
      end
    end
  end

endmodule
